// File: rtl/cycle_display.sv
// Cycle-count display: captures a 16-bit count, converts it to five BCD digits by double-dabble
// and drives active-low seven-segment outputs. Optional macro CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN.
module cycle_display (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] count_in,
  input  logic [3:0]  instr,
  input  logic        load,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic        busy,
  output logic        valid
);

  localparam logic [3:0] StopOpcode = 4'b0001;
  localparam logic [6:0] SegBlank   = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

  state_e          state_q;
  logic            stop_prev_q;
  logic [15:0]     bin_q;
  logic [19:0]     bcd_q;
  logic [4:0]      iter_q;
  logic [4:0][6:0] disp_q;

  logic            is_stop;
  logic            capture;
  logic [19:0]     bcd_adj;
  logic [4:0]      show;
  logic [4:0][6:0] disp_d;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  assign is_stop = (instr == StopOpcode);
  assign capture = load | (is_stop & ~stop_prev_q);

  // Add-3 correction applied before each shift keeps every nibble within 0..9.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN
    // A digit is shown once any digit at or above it is non-zero; hex0 always shown.
    show[4] = (bcd_q[19:16] != 4'd0);
    show[3] = show[4] | (bcd_q[15:12] != 4'd0);
    show[2] = show[3] | (bcd_q[11:8] != 4'd0);
    show[1] = show[2] | (bcd_q[7:4] != 4'd0);
    show[0] = 1'b1;
`else
    show = 5'b11111;
`endif
    disp_d = '1;
    for (int i = 0; i < 5; i++) begin
      disp_d[i] = show[i] ? seg(bcd_q[4*i +: 4]) : SegBlank;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      valid       <= 1'b0;
      disp_q      <= '1;
      stop_prev_q <= 1'b0;
      iter_q      <= 5'd0;
      bin_q       <= 16'd0;
      bcd_q       <= 20'd0;
    end else begin
      stop_prev_q <= is_stop;
      case (state_q)
        StIdle: begin
          if (capture) begin
            bin_q   <= count_in;
            bcd_q   <= 20'd0;
            iter_q  <= 5'd0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          {bcd_q, bin_q} <= {bcd_adj[18:0], bin_q, 1'b0};
          iter_q         <= iter_q + 5'd1;
          if (iter_q == 5'd15) state_q <= StUpdate;
        end
        StUpdate: begin
          disp_q  <= disp_d;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hex0 = disp_q[0];
  assign hex1 = disp_q[1];
  assign hex2 = disp_q[2];
  assign hex3 = disp_q[3];
  assign hex4 = disp_q[4];

endmodule

// File: tb/tb_cycle_display.sv
// Self-checking bench for cycle_display: directed scenarios plus a randomized sweep against a
// decimal-arithmetic reference model.
module tb_cycle_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] count_in;
  logic [3:0]  instr;
  logic        load;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4;
  logic        busy;
  logic        valid;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [34:0] shown_exp;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  cycle_display dut (
    .clock    (clock),
    .reset    (reset),
    .count_in (count_in),
    .instr    (instr),
    .load     (load),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .busy     (busy),
    .valid    (valid)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Expected {hex4..hex0} for a decimal value.
  function automatic logic [34:0] exp_hex(input int unsigned v);
    logic [34:0] r;
    int unsigned p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[7*i +: 7] = seg_tab[(v / p) % 10];
`ifdef CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) r[7*i +: 7] = 7'h7f;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [34:0] dut_hex();
    return {hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; instr = 4'd0; count_in = 16'd123;
    step_n(2);
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b valid=%b want 0/0", busy, valid);
    end
    n_cmp++;
    if (dut_hex() !== {35{1'b1}}) begin
      n_fail++; $display("FAIL reset_hex: got %h want all ones", dut_hex());
    end
    reset = 1'b0; load = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_capture: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_load_1234();
    count_in = 16'd1234; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL load_start: got busy=%b valid=%b want 1/0", busy, valid);
    end
    step_n(16);
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL load_n16: got busy=%b valid=%b want 1/0", busy, valid);
    end
    step();
    n_cmp++;
    if (dut_hex() !== exp_hex(1234) || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_1234: got hex=%h v=%b b=%b want hex=%h v=1 b=0",
               dut_hex(), valid, busy, exp_hex(1234));
    end
  endtask

  task automatic test_stop_hold();
    int rises;
    logic prev;
    instr = 4'd0;
    step();
    count_in = 16'd65535; instr = 4'b0001;
    rises = 0; prev = busy;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy === 1'b1 && prev !== 1'b1) rises++;
      prev = busy;
      if (i == 17) begin
        n_cmp++;
        if (dut_hex() !== exp_hex(65535) || valid !== 1'b1) begin
          n_fail++; $display("FAIL stop_65535: got %h v=%b want %h v=1",
                             dut_hex(), valid, exp_hex(65535));
        end
      end
    end
    n_cmp++;
    if (rises != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_single: got rises=%0d busy=%b want 1/0", rises, busy);
    end
    instr = 4'd0;
    step();
  endtask

  task automatic test_zero();
    count_in = 16'd0; load = 1'b1;
    step();
    load = 1'b0;
    step_n(17);
    n_cmp++;
    if (dut_hex() !== exp_hex(0) || valid !== 1'b1) begin
      n_fail++; $display("FAIL zero: got %h v=%b want %h v=1", dut_hex(), valid, exp_hex(0));
    end
  endtask

  task automatic test_ignore_busy();
    int busy_cnt;
    count_in = 16'd42; load = 1'b1;
    step();
    load = 1'b0; count_in = 16'd777;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 17; k++) begin
      load = (k == 5);
      step();
      if (busy === 1'b1) busy_cnt++;
    end
    load = 1'b0;
    n_cmp++;
    if (busy_cnt != 17) begin
      n_fail++; $display("FAIL busy_len: got %0d want 17", busy_cnt);
    end
    n_cmp++;
    if (dut_hex() !== exp_hex(42) || valid !== 1'b1) begin
      n_fail++; $display("FAIL ignore_42: got %h v=%b want %h v=1", dut_hex(), valid, exp_hex(42));
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b1) begin
      n_fail++; $display("FAIL no_queue: got busy=%b valid=%b want 0/1", busy, valid);
    end
  endtask

  task automatic test_reset_abort();
    count_in = 16'd999; load = 1'b1;
    step();
    load = 1'b0;
    step_n(8);
    reset = 1'b1;
    step();
    n_cmp++;
    if (dut_hex() !== {35{1'b1}} || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort: got %h v=%b b=%b want all ones v=0 b=0",
                         dut_hex(), valid, busy);
    end
    reset = 1'b0;
    step_n(20);
    n_cmp++;
    if (dut_hex() !== {35{1'b1}} || busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_stays: got %h b=%b v=%b want all ones 0/0",
                         dut_hex(), busy, valid);
    end
    count_in = 16'd7; load = 1'b1;
    step();
    load = 1'b0;
    step_n(17);
    n_cmp++;
    if (dut_hex() !== exp_hex(7) || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL after_abort_7: got %h v=%b b=%b want %h v=1 b=0",
                         dut_hex(), valid, busy, exp_hex(7));
    end
  endtask

  task automatic test_reset_stop();
    count_in = 16'd31; instr = 4'b0001; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_stop: got busy=%b want 1", busy);
    end
    instr = 4'd0;
    step_n(17);
    n_cmp++;
    if (dut_hex() !== exp_hex(31) || valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_31: got %h v=%b want %h v=1", dut_hex(), valid, exp_hex(31));
    end
  endtask

  task automatic test_same_cycle();
    instr = 4'd0;
    step();
    count_in = 16'd5508; load = 1'b1; instr = 4'b0001;
    step();
    load = 1'b0; instr = 4'd0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL same_start: got busy=%b want 1", busy);
    end
    step_n(17);
    n_cmp++;
    if (dut_hex() !== exp_hex(5508) || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL same_5508: got %h v=%b b=%b want %h v=1 b=0",
                         dut_hex(), valid, busy, exp_hex(5508));
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL same_single: got busy=%b want 0", busy);
    end
    shown_exp = exp_hex(5508);
  endtask

  task automatic test_random_sweep();
    int unsigned sp [6] = '{9, 10, 99, 100, 9999, 10000};
    int unsigned v;
    int bad;
    for (int n = 0; n < 200; n++) begin
      v = (n < 6) ? sp[n] : $urandom_range(0, 65535);
      count_in = v[15:0];
      if ($urandom_range(0, 1) == 0) load = 1'b1;
      else instr = 4'b0001;
      step();
      load = 1'b0; instr = 4'd0;
      n_cmp++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        n_fail++; $display("FAIL sweep_start %0d: got busy=%b valid=%b want 1/0", v, busy, valid);
      end
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
        count_in = 16'($urandom);
        step();
        if (busy !== 1'b1 || valid !== 1'b0 || dut_hex() !== shown_exp) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++; $display("FAIL sweep_hold %0d: got %0d bad cycles want 0", v, bad);
      end
      step();
      n_cmp++;
      if (dut_hex() !== exp_hex(v) || valid !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL sweep_value %0d: got %h v=%b b=%b want %h v=1 b=0",
                           v, dut_hex(), valid, busy, exp_hex(v));
      end
      shown_exp = exp_hex(v);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; instr = 4'd0; count_in = 16'd0;
    test_reset();
    test_load_1234();
    test_stop_hold();
    test_zero();
    test_ignore_busy();
    test_reset_abort();
    test_reset_stop();
    test_same_cycle();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_display.md
CYCLE_DISPLAY -- requirements
Module: cycle_display

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high; clock clock.
REQ-003 SHALL have port count_in, input, 16 bits: unsigned cycle count from the upstream cycle counter.
REQ-004 SHALL have port instr, input, 4 bits: current opcode; 4'b0001 is the stop opcode.
REQ-005 SHALL have port load, input, 1 bit: manual capture request, sampled each clock.
REQ-006 SHALL have ports hex0..hex4, output, 7 bits each: active-low seven-segment digits.
- hex0 is the least significant digit.
- Bit 0 is segment a and bit 6 is segment g.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port valid, output, 1 bit: high while the displays hold a completed conversion.

Function
REQ-009 SHALL implement a 3-state FSM: IDLE, CONVERT, UPDATE.
REQ-010 SHALL define a capture request as either of:
- load==1;
- the rising edge of (instr==4'b0001), detected against a registered previous-cycle compare.
REQ-011 In IDLE, on a capture request, SHALL:
- latch count_in into a 16-bit shift register;
- clear the 20-bit BCD register and the 5-bit iteration counter;
- enter CONVERT.
REQ-012 In CONVERT, SHALL perform one double-dabble step per clock:
- add 3 to each BCD nibble >=5;
- then shift {BCD,bin} left by one bit.
REQ-013 SHALL leave CONVERT for UPDATE after exactly 16 steps.
REQ-014 In UPDATE, SHALL:
- load hex0..hex4 from the BCD nibbles via the segment map;
- set valid=1;
- return to IDLE.
REQ-015 SHALL use this segment map, value -> 7-bit pattern written g..a:
- 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001;
- 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000;
- blank:1111111.
REQ-016 SHALL fix latency: request sampled at edge N -> busy=1 after edge N; displays updated and valid=1 after edge N+17; busy=0 after edge N+17.
REQ-017 SHALL ignore capture requests while busy=1, with no queueing.
REQ-018 SHALL clear valid when a new capture is accepted, and SHALL keep hex0..hex4 at their previous values until UPDATE.
REQ-019 SHALL hold the stop opcode steady for many cycles as a single capture: no re-capture until instr leaves 4'b0001 and returns.
REQ-020 SHALL accept a capture when load and a stop edge occur in the same cycle, as one capture.
REQ-021 SHALL convert boundary values exactly:
- count_in=0 -> digits 00000;
- count_in=65535 -> digits 65535.
REQ-022 SHALL never produce a BCD nibble >9.
REQ-023 SHALL drive busy and valid from registers only.

Reset
REQ-024 SHALL, on reset=1 at a clock edge:
- set FSM=IDLE, busy=0, valid=0;
- set hex0..hex4=1111111 (blank);
- clear the previous-stop flag, iteration counter, and shift/BCD registers.
REQ-025 SHALL give reset priority over all other inputs.
REQ-026 SHALL abort an in-progress conversion on reset, with no display update.
REQ-027 SHALL NOT capture in the cycle reset is asserted.
REQ-028 SHALL allow a stop edge after reset: if instr==4'b0001 in the first post-reset cycle, that cycle SHALL count as a rising edge.

Configuration
REQ-029 SHALL use macro CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN.
REQ-030 When CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN is defined, SHALL blank in UPDATE every zero digit of hex4..hex1 that has only zeros above it; hex0 SHALL always be shown.
REQ-031 When CYCLE_DISPLAY_LEADING_ZERO_BLANK_EN is undefined, SHALL show all five digits, including leading zeros.
REQ-032 SHALL keep timing, FSM, and all other behaviour identical with and without the macro.

Verification
REQ-033 Reset, then load=1 with count_in=16'd1234 -> after 17 edges:
- macro off: hex4..hex0 = 0,1,2,3,4;
- macro on: hex4 blank, hex3..hex0 = 1,2,3,4;
- valid=1, busy=0.
REQ-034 instr=4'b0001 held 40 cycles with count_in=16'd65535 -> exactly one conversion; digits 6,5,5,3,5; no second busy pulse.
REQ-035 count_in=0, load=1 -> macro off: all digits 0; macro on: hex4..hex1 blank, hex0=0.
REQ-036 load pulsed again at cycle 5 of a conversion of 16'd42 -> request ignored; result 42 at edge N+17; busy stays high 17 edges total.
REQ-037 reset asserted at cycle 8 of a conversion of 16'd999 -> all hex=1111111, valid=0, busy=0; a subsequent load of 16'd7 yields 7 after 17 edges.
REQ-038 Randomised sweep of 200 values, including 9, 10, 99, 100, 9999, 10000 -> displayed digits match the decimal value and REQ-016 latency is met.
